// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the serial arithmetic blocks.
package serial_arith_pkg;

    // Control states of a serial operation.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Number of digit steps needed for one WIDTH-bit operation.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of a counter that indexes ndig steps; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_engine_digit_adder.sv
// Combinational DIGIT-bit ripple adder: a + b + cin.
// c_msb is the carry entering the top bit, needed for signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub_engine.sv
// Serial adder/subtractor: processes two WIDTH-bit operands LSB-first,
// DIGIT bits per clock, streaming sum digits and then presenting the full
// result with carry/no-borrow and signed overflow.
module serial_addsub_engine
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             digit_valid,
    output logic [DIGIT-1:0] sum_digit,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_width(NDIG);

    state_t           state_reg;
    state_t           state_next;
    logic             armed_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             last_digit;

    logic             digit_valid_reg;
    logic [DIGIT-1:0] sum_digit_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;

    logic [DIGIT-1:0] add_sum;
    logic             add_cout;
    logic             add_c_msb;

    // One digit step of the running sum.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (a_reg[DIGIT-1:0]),
        .b     (b_reg[DIGIT-1:0]),
        .cin   (carry_reg),
        .sum   (add_sum),
        .cout  (add_cout),
        .c_msb (add_c_msb)
    );

    assign last_digit = (cnt_reg == CW'(NDIG - 1));

    // New digit enters the accumulator from the MSB side so the LSB digit
    // lands at bit 0 after NDIG steps.
    assign acc_next = (acc_reg >> DIGIT) | (WIDTH'(add_sum) << (WIDTH - DIGIT));

    // Hold ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; start beats abort in IDLE because abort is only honoured in RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && ready) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_digit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ready = (state_reg == S_IDLE) && armed_reg;
        busy  = (state_reg == S_RUN);
    end

    // Operand, accumulator and registered-output datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            carry_reg       <= 1'b0;
            acc_reg         <= '0;
            digit_valid_reg <= 1'b0;
            sum_digit_reg   <= '0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
            carry_out_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    digit_valid_reg <= 1'b0;
                    done_reg        <= 1'b0;
                    if (start && ready) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        a_reg     <= a_in;
                        b_reg     <= b_in ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Published result/flags keep the last completed operation.
                        digit_valid_reg <= 1'b0;
                    end else begin
                        sum_digit_reg   <= add_sum;
                        digit_valid_reg <= 1'b1;
                        acc_reg         <= acc_next;
                        a_reg           <= a_reg >> DIGIT;
                        b_reg           <= b_reg >> DIGIT;
                        carry_reg       <= add_cout;
                        cnt_reg         <= cnt_reg + CW'(1);
                        if (last_digit) begin
                            result_reg    <= acc_next;
                            carry_out_reg <= add_cout;
                            overflow_reg  <= add_c_msb ^ add_cout;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    digit_valid_reg <= 1'b0;
                    done_reg        <= 1'b0;
                end
                default: begin
                    digit_valid_reg <= 1'b0;
                    done_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign digit_valid = digit_valid_reg;
    assign sum_digit   = sum_digit_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign carry_out   = carry_out_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Bench for serial_addsub_engine: an 8-bit/1-bit instance checked every cycle
// against an arithmetic model, and a 16-bit/4-bit instance checked against
// hand-computed digit and result tables.
module tb_serial_addsub_engine;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // 8-bit, 1-bit-digit instance
    logic       start8 = 1'b0, sub8 = 1'b0, abort8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, dv8, done8, cout8, ovf8;
    logic [0:0] dig8;
    logic [7:0] res8;

    serial_addsub_engine #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
        .abort(abort8), .ready(ready8), .busy(busy8), .digit_valid(dv8),
        .sum_digit(dig8), .done(done8), .result(res8), .carry_out(cout8),
        .overflow(ovf8)
    );

    // 16-bit, 4-bit-digit instance
    logic        start16 = 1'b0, sub16 = 1'b0, abort16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, busy16, dv16, done16, cout16, ovf16;
    logic [3:0]  dig16;
    logic [15:0] res16;

    serial_addsub_engine #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a_in(a16), .b_in(b16),
        .abort(abort16), .ready(ready16), .busy(busy16), .digit_valid(dv16),
        .sum_digit(dig16), .done(done16), .result(res16), .carry_out(cout16),
        .overflow(ovf16)
    );

    // Hand-computed results of the completed 8-bit operations, in order.
    logic [7:0] lit8_r [6] = '{8'h96, 8'h00, 8'hF0, 8'h7F, 8'h77, 8'h80};
    logic       lit8_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       lit8_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Hand-computed 16-bit operations.
    logic [15:0] t16_a [3] = '{16'h1234, 16'h1234, 16'h7FFF};
    logic [15:0] t16_b [3] = '{16'hEDCC, 16'h0235, 16'h0001};
    logic        t16_s [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] t16_r [3] = '{16'h0000, 16'h0FFF, 16'h8000};
    logic        t16_c [3] = '{1'b1, 1'b1, 1'b0};
    logic        t16_v [3] = '{1'b0, 1'b0, 1'b1};

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model of the 8-bit instance
    int   m_phase = 0;      // 0 idle, 1 running, 2 result cycle
    int   m_k = 0;
    int   m_edge = 0, m_start_edge = 0;
    int   m_exp = 0, m_ecout = 0, m_eovf = 0;
    logic m_armed = 0, m_ready = 0, m_busy = 0, m_dv = 0, m_done = 0;
    logic m_digit = 0, m_cout = 0, m_ovf = 0;
    logic [7:0] m_res = '0;

    always @(posedge clk or negedge reset) begin
        int a, b, sa, sb, sr;
        if (!reset) begin
            m_phase = 0; m_k = 0; m_armed = 0; m_dv = 0; m_done = 0;
            m_digit = 0; m_cout = 0; m_ovf = 0; m_res = '0;
        end else begin
            m_edge++;
            case (m_phase)
                0: begin
                    m_dv = 0; m_done = 0;
                    if (start8 && m_armed) begin
                        a = int'(a8); b = int'(b8);
                        sa = (a >= 128) ? a - 256 : a;
                        sb = (b >= 128) ? b - 256 : b;
                        if (sub8) begin
                            m_exp   = (a - b + 256) % 256;
                            m_ecout = (a >= b) ? 1 : 0;
                            sr      = sa - sb;
                        end else begin
                            m_exp   = (a + b) % 256;
                            m_ecout = (a + b > 255) ? 1 : 0;
                            sr      = sa + sb;
                        end
                        m_eovf = (sr > 127 || sr < -128) ? 1 : 0;
                        m_k = 0;
                        m_start_edge = m_edge;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (abort8) begin
                        m_dv = 0;
                        m_phase = 0;
                    end else begin
                        m_dv = 1;
                        m_digit = ((m_exp >> m_k) & 1) != 0;
                        m_k++;
                        if (m_k == 8) begin
                            m_res  = 8'(m_exp);
                            m_cout = m_ecout != 0;
                            m_ovf  = m_eovf != 0;
                            m_done = 1;
                            m_phase = 2;
                        end
                    end
                end
                default: begin
                    m_dv = 0; m_done = 0;
                    m_phase = 0;
                end
            endcase
            m_armed = 1;
        end
        m_ready = (m_phase == 0) && m_armed;
        m_busy  = (m_phase == 1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare process: after every clock edge and on reset assertion.
    int n8 = 0;
    int k16 = -1;
    int op16 = 0;
    always begin
        int d;
        @(posedge clk or negedge reset);
        #2;
        chk("ready8",  32'(ready8), 32'(m_ready));
        chk("busy8",   32'(busy8),  32'(m_busy));
        chk("dvalid8", 32'(dv8),    32'(m_dv));
        chk("digit8",  32'(dig8),   32'(m_digit));
        chk("done8",   32'(done8),  32'(m_done));
        chk("result8", 32'(res8),   32'(m_res));
        chk("carry8",  32'(cout8),  32'(m_cout));
        chk("ovf8",    32'(ovf8),   32'(m_ovf));
        if (m_done && n8 < 6) begin
            chk("pin_result8",  32'(m_res),  32'(lit8_r[n8]));
            chk("pin_carry8",   32'(m_cout), 32'(lit8_c[n8]));
            chk("pin_ovf8",     32'(m_ovf),  32'(lit8_v[n8]));
            chk("pin_latency8", 32'(m_edge - m_start_edge), 32'd8);
            n8++;
        end

        if (!reset) begin
            k16 = -1;
            chk("rst_ready16", 32'(ready16), 32'd0);
            chk("rst_outs16",  32'({dv16, dig16, done16, res16, cout16, ovf16}), 32'd0);
        end else if (k16 >= 0) begin
            k16++;
        end else if (start16 && op16 < 3) begin
            k16 = 0;
        end

        if (k16 == 0) begin
            chk("busy16",   32'(busy16), 32'd1);
            chk("dvalid16", 32'(dv16),   32'd0);
        end else if (k16 >= 1 && k16 <= 4) begin
            d = (int'(t16_r[op16]) >> (4 * (k16 - 1))) & 15;
            chk("dvalid16", 32'(dv16),   32'd1);
            chk("digit16",  32'(dig16),  32'(d));
            chk("done16",   32'(done16), (k16 == 4) ? 32'd1 : 32'd0);
            if (k16 == 4) begin
                chk("result16", 32'(res16),  32'(t16_r[op16]));
                chk("carry16",  32'(cout16), 32'(t16_c[op16]));
                chk("ovf16",    32'(ovf16),  32'(t16_v[op16]));
            end
        end else if (k16 == 5) begin
            chk("ready16",  32'(ready16), 32'd1);
            chk("done16",   32'(done16),  32'd0);
            chk("dvalid16", 32'(dv16),    32'd0);
            k16 = -1;
            op16++;
        end
    end

    // One 8-bit operation: start for one cycle, then let it run.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int wait_cycles);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        repeat (wait_cycles) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 0x5A+0x3C, with a stray start during the result cycle
        op8(8'h5A, 8'h3C, 1'b0, 8);
        start8 = 1'b1; a8 = 8'hEE; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        op8(8'hFF, 8'h01, 1'b0, 10);
        op8(8'h10, 8'h20, 1'b1, 10);
        op8(8'h80, 8'h01, 1'b1, 10);

        // Start during RUN is ignored; abort after three digits
        op8(8'h11, 8'h22, 1'b0, 1);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        // Start and abort together in IDLE: start wins
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of an operation
        op8(8'h12, 8'h34, 1'b0, 3);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        op8(8'h7F, 8'h01, 1'b0, 10);

        // 16-bit, 4-bit-digit operations
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start16 = 1'b1; a16 = t16_a[i]; b16 = t16_b[i]; sub16 = t16_s[i];
            @(negedge clk);
            start16 = 1'b0;
            repeat (6) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        if (n8 != 6) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_count8: got %0d completions, expected 6", n8);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
